// File: rtl/ifu_ram_resp_pkg.sv
// ifu_ram_resp_pkg -- shared definitions for the instruction-fetch RAM
// responder: controller state encoding, the NOP returned for illegal fetches,
// the reset PC (also the default base of the backing memory) and a helper
// that picks one 32-bit instruction out of a 64-bit memory word.
package ifu_ram_resp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } ifu_state_t;

    // addi x0, x0, 0 -- harmless filler returned with o_err on illegal fetches
    localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
    localparam logic [63:0] PC_START  = 64'h8000_0000;
    localparam logic [2:0]  SIZE_WORD = 3'b010;

    // Byte address bit 2 selects the upper or lower instruction of a word.
    function automatic logic [31:0] select_half(input logic [63:0] line,
                                                input logic        upper);
        return upper ? line[63:32] : line[31:0];
    endfunction

endpackage

// File: rtl/ifu_ram_resp_if.sv
// ifu_ram_resp_if -- fetch request/response channel plus the backing-memory
// read port of the fetch RAM responder.
//   Fetch side : i_ram_addr, i_ram_valid, i_ram_size, i_inv (initiator -> responder)
//                o_ram_ready, o_ram_rdata, o_err        (responder -> initiator)
//   Memory side: o_mem_en, o_mem_addr (responder -> memory), i_mem_rdata (memory -> responder)
// Modports: slave = responder view, master = environment (initiator + memory) view.
interface ifu_ram_resp_if #(
    parameter int unsigned MEM_AW = 16
);
    logic [63:0]       i_ram_addr;
    logic              i_ram_valid;
    logic [2:0]        i_ram_size;
    logic              i_inv;
    logic              o_ram_ready;
    logic [31:0]       o_ram_rdata;
    logic              o_err;
    logic              o_mem_en;
    logic [MEM_AW-1:0] o_mem_addr;
    logic [63:0]       i_mem_rdata;

    modport slave (
        input  i_ram_addr, i_ram_valid, i_ram_size, i_inv, i_mem_rdata,
        output o_ram_ready, o_ram_rdata, o_err, o_mem_en, o_mem_addr
    );

    modport master (
        output i_ram_addr, i_ram_valid, i_ram_size, i_inv, i_mem_rdata,
        input  o_ram_ready, o_ram_rdata, o_err, o_mem_en, o_mem_addr
    );
endinterface

// File: rtl/ifu_ram_linebuf.sv
// ifu_ram_linebuf -- single 64-bit line buffer holding the last fetched
// memory word with its tag (byte address bits [63:3]).
//   clk, rst_n  : clock, synchronous active-low reset (clears valid only)
//   fill_en     : write fill_tag/fill_data and mark the line valid
//   inv         : invalidate; wins over a coincident fill
//   valid/tag/data : current line contents
module ifu_ram_linebuf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fill_en,
    input  logic [60:0] fill_tag,
    input  logic [63:0] fill_data,
    input  logic        inv,
    output logic        valid,
    output logic [60:0] tag,
    output logic [63:0] data
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (inv) begin
            valid <= 1'b0;
        end else if (fill_en) begin
            valid <= 1'b1;
        end
    end

    // NOTE: tag/data are storage qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag  <= fill_tag;
            data <= fill_data;
        end
    end

endmodule

// File: rtl/ifu_ram_resp.sv
// ifu_ram_resp -- answers 32-bit instruction fetches from a 64-bit backing
// memory with fixed read latency, through a one-line buffer.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : ifu_ram_resp_if.slave (fetch channel + memory read port)
// A request is captured in IDLE. Illegal requests answer NOP with o_err,
// buffer hits answer one cycle later, misses read memory (ISSUE, WAIT) and
// answer MEM_LAT+2 cycles after capture. RESP lasts one cycle; ready is only
// shown while the initiator still presents the captured address.
module ifu_ram_resp
    import ifu_ram_resp_pkg::*;
#(
    parameter int unsigned MEM_LAT   = 2,
    parameter int unsigned MEM_AW    = 16,
    parameter logic [63:0] BASE_ADDR = PC_START
) (
    input logic              clk,
    input logic              rst_n,
    ifu_ram_resp_if.slave    bus
);

    ifu_state_t        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [63:0]       cap_addr_q;
    logic [31:0]       rdata_q;
    logic              mem_en_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic              err_q;

    logic [63:0]       word_idx;
    logic              req_illegal;
    logic              lb_valid;
    logic [60:0]       lb_tag;
    logic [63:0]       lb_data;
    logic              lb_hit;
    logic              capture;
    logic              fill_en;

    // Addresses below BASE_ADDR wrap to huge indices and fail the range test
    // too; the explicit compare keeps the intent obvious.
    assign word_idx    = (bus.i_ram_addr - BASE_ADDR) >> 3;
    assign req_illegal = (bus.i_ram_size != SIZE_WORD)
                       || (bus.i_ram_addr[1:0] != 2'b00)
                       || (bus.i_ram_addr < BASE_ADDR)
                       || ((word_idx >> MEM_AW) != 64'd0);

    assign lb_hit  = lb_valid && (lb_tag == bus.i_ram_addr[63:3]);
    assign capture = (state_q == IDLE) && bus.i_ram_valid;

    ifu_ram_linebuf u_linebuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .fill_en   (fill_en),
        .fill_tag  (cap_addr_q[63:3]),
        .fill_data (bus.i_mem_rdata),
        .inv       (bus.i_inv),
        .valid     (lb_valid),
        .tag       (lb_tag),
        .data      (lb_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no branch leaves an output unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_ram_valid) begin
                    state_d = (req_illegal || lb_hit) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = 3'(MEM_LAT);
            end
            WAIT: begin
                // Final WAIT cycle is the one where memory data is valid.
                if (cnt_q <= 3'd1) begin
                    fill_en = 1'b1;
                    cnt_d   = 3'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs are loaded with the value they must show in the
    // state being entered, so they line up with ISSUE/RESP exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_addr_q <= BASE_ADDR;
            rdata_q    <= '0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            err_q      <= 1'b0;
        end else begin
            mem_en_q <= (state_d == ISSUE);
            err_q    <= capture && req_illegal;
            if (capture) begin
                cap_addr_q <= bus.i_ram_addr;
                if (!req_illegal) begin
                    mem_addr_q <= word_idx[MEM_AW-1:0];
                end
            end
            if (capture && req_illegal) begin
                rdata_q <= NOP_INSN;
            end else if (capture && lb_hit) begin
                rdata_q <= select_half(lb_data, bus.i_ram_addr[2]);
            end else if (fill_en) begin
                rdata_q <= select_half(bus.i_mem_rdata, cap_addr_q[2]);
            end
        end
    end

    // Only combinational input-to-output path: a stale or redirected request
    // never sees ready.
    assign bus.o_ram_ready = (state_q == RESP) && bus.i_ram_valid
                           && (bus.i_ram_addr == cap_addr_q);
    assign bus.o_ram_rdata = rdata_q;
    assign bus.o_err       = err_q;
    assign bus.o_mem_en    = mem_en_q;
    assign bus.o_mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_ifu_ram_resp.sv
// tb_ifu_ram_resp -- self-checking bench for ifu_ram_resp.
// Inputs are driven 1 ns after the rising edge, outputs sampled on the
// falling edge. A transaction-level model predicts, per captured request,
// the cycle of the memory strobe and of the response, plus the line buffer
// contents; a bench memory answers o_mem_en exactly MEM_LAT cycles later.
module tb_ifu_ram_resp;

    localparam int unsigned L    = 2;
    localparam int unsigned AW   = 16;
    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifu_ram_resp_if #(.MEM_AW(AW)) bus ();

    ifu_ram_resp #(.MEM_LAT(L), .MEM_AW(AW), .BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_total = 0;
    int n_pass  = 0;
    longint cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [63:0] idx);
        return {idx[31:0] ^ 32'hC0DE_0000, ~idx[31:0] ^ 32'h1234_5678};
    endfunction

    // ---------------- bench memory ----------------
    logic        sched_v [8];
    logic [63:0] sched_d [8];

    task automatic drive_mem();
        if (bus.o_mem_en === 1'b1) begin
            sched_v[(cyc + L) % 8] = 1'b1;
            sched_d[(cyc + L) % 8] = mem_word(64'(bus.o_mem_addr));
        end
        if (sched_v[cyc % 8]) begin
            bus.i_mem_rdata = sched_d[cyc % 8];
            sched_v[cyc % 8] = 1'b0;
        end else begin
            bus.i_mem_rdata = {$urandom, $urandom};
        end
    endtask

    // ---------------- reference model ----------------
    longint      m_idle_at, m_resp_cyc, m_issue_cyc, m_fill_cyc;
    logic [63:0] m_resp_addr, m_issue_idx, m_fill_data;
    logic [31:0] m_resp_data;
    logic        m_resp_err;
    logic [60:0] m_fill_tag;
    logic        mb_valid;
    logic [60:0] mb_tag;
    logic [63:0] mb_data;

    logic        act_ready, act_err, act_mem_en;
    logic [31:0] act_rdata;

    task automatic model_reset();
        mb_valid    = 1'b0;
        m_idle_at   = cyc;
        m_resp_cyc  = -1;
        m_issue_cyc = -1;
        m_fill_cyc  = -1;
        for (int i = 0; i < 8; i++) sched_v[i] = 1'b0;
    endtask

    task automatic run_cycle(input logic v, input logic [63:0] a,
                             input logic [2:0] sz, input logic inv);
        logic        bad, exp_rdy, exp_en, exp_err;
        logic [63:0] idx;
        drive_mem();
        bus.i_ram_valid = v;
        bus.i_ram_addr  = a;
        bus.i_ram_size  = sz;
        bus.i_inv       = inv;
        if (cyc >= m_idle_at && v) begin
            bad = (sz != 3'b010) || (a[1:0] != 2'b00) || (a < BASE)
                  || (a >= BASE + (64'd8 << AW));
            idx = (a - BASE) >> 3;
            m_resp_addr = a;
            m_resp_err  = bad;
            if (bad) begin
                m_resp_cyc  = cyc + 1;
                m_resp_data = NOP;
            end else if (mb_valid && mb_tag == a[63:3]) begin
                m_resp_cyc  = cyc + 1;
                m_resp_data = a[2] ? mb_data[63:32] : mb_data[31:0];
            end else begin
                m_issue_cyc = cyc + 1;
                m_issue_idx = idx;
                m_fill_cyc  = cyc + L + 1;
                m_fill_tag  = a[63:3];
                m_fill_data = mem_word(idx);
                m_resp_cyc  = cyc + L + 2;
                m_resp_data = a[2] ? m_fill_data[63:32] : m_fill_data[31:0];
            end
            m_idle_at = m_resp_cyc + 1;
        end
        exp_rdy = (cyc == m_resp_cyc) && v && (a == m_resp_addr);
        exp_en  = (cyc == m_issue_cyc);
        exp_err = (cyc == m_resp_cyc) && m_resp_err;
        @(negedge clk);
        act_ready  = bus.o_ram_ready;
        act_err    = bus.o_err;
        act_mem_en = bus.o_mem_en;
        act_rdata  = bus.o_ram_rdata;
        check($sformatf("ready@%0d", cyc), 64'(act_ready), 64'(exp_rdy));
        check($sformatf("mem_en@%0d", cyc), 64'(act_mem_en), 64'(exp_en));
        check($sformatf("err@%0d", cyc), 64'(act_err), 64'(exp_err));
        if (exp_rdy) check($sformatf("rdata@%0d", cyc), 64'(act_rdata), 64'(m_resp_data));
        if (exp_en) check($sformatf("mem_addr@%0d", cyc), 64'(bus.o_mem_addr), 64'(m_issue_idx[AW-1:0]));
        if (cyc == m_fill_cyc) begin
            mb_valid = 1'b1;
            mb_tag   = m_fill_tag;
            mb_data  = m_fill_data;
        end
        if (inv) mb_valid = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n, input logic v, input logic [63:0] a);
        rst_n = 1'b0;
        bus.i_ram_valid = v;
        bus.i_ram_addr  = a;
        bus.i_ram_size  = 3'b010;
        bus.i_inv       = 1'b0;
        for (int k = 0; k < n; k++) begin
            bus.i_mem_rdata = {$urandom, $urandom};
            @(negedge clk);
            if (k >= 1) begin
                check("rst_ready", 64'(bus.o_ram_ready), 64'd0);
                check("rst_mem_en", 64'(bus.o_mem_en), 64'd0);
                check("rst_err", 64'(bus.o_err), 64'd0);
                check("rst_rdata", 64'(bus.o_ram_rdata), 64'd0);
                check("rst_mem_addr", 64'(bus.o_mem_addr), 64'd0);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v;
        logic [63:0] a;
        logic [2:0]  sz;
        logic        rdy;
        logic        en;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [63:0] a, input logic [2:0] sz,
                                input logic rdy, input logic en, input logic err,
                                input logic [31:0] rdata);
        vec_t r;
        r.v = v; r.a = a; r.sz = sz; r.rdy = rdy; r.en = en; r.err = err; r.rdata = rdata;
        return r;
    endfunction

    vec_t vecs [17];

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] w0;
        logic        rv, seen;
        logic [63:0] ra;
        logic [2:0]  rs;
        int          at;

        w0 = mem_word(64'd0);
        // Miss to word 0 (strobe at cycle 1, ready at 4), then hit on the
        // upper half, then the four illegal flavours (2 rows each).
        vecs[0]  = mk(1, 64'h8000_0000, 3'b010, 0, 0, 0, 32'h0);
        vecs[1]  = mk(1, 64'h8000_0000, 3'b010, 0, 1, 0, 32'h0);
        vecs[2]  = mk(1, 64'h8000_0000, 3'b010, 0, 0, 0, 32'h0);
        vecs[3]  = mk(1, 64'h8000_0000, 3'b010, 0, 0, 0, 32'h0);
        vecs[4]  = mk(1, 64'h8000_0000, 3'b010, 1, 0, 0, w0[31:0]);
        vecs[5]  = mk(1, 64'h8000_0004, 3'b010, 0, 0, 0, 32'h0);
        vecs[6]  = mk(1, 64'h8000_0004, 3'b010, 1, 0, 0, w0[63:32]);
        vecs[7]  = mk(0, 64'h8000_0004, 3'b010, 0, 0, 0, 32'h0);
        vecs[8]  = mk(1, 64'h8000_0000, 3'b011, 0, 0, 0, 32'h0);
        vecs[9]  = mk(1, 64'h8000_0000, 3'b011, 1, 0, 1, NOP);
        vecs[10] = mk(1, 64'h8000_0002, 3'b010, 0, 0, 0, 32'h0);
        vecs[11] = mk(1, 64'h8000_0002, 3'b010, 1, 0, 1, NOP);
        vecs[12] = mk(1, 64'h7FFF_FFFC, 3'b010, 0, 0, 0, 32'h0);
        vecs[13] = mk(1, 64'h7FFF_FFFC, 3'b010, 1, 0, 1, NOP);
        vecs[14] = mk(1, 64'h8008_0000, 3'b010, 0, 0, 0, 32'h0);
        vecs[15] = mk(1, 64'h8008_0000, 3'b010, 1, 0, 1, NOP);
        vecs[16] = mk(0, 64'h8000_0000, 3'b010, 0, 0, 0, 32'h0);

        bus.i_ram_valid = 1'b0;
        bus.i_ram_addr  = BASE;
        bus.i_ram_size  = 3'b010;
        bus.i_inv       = 1'b0;
        bus.i_mem_rdata = '0;
        do_reset(3, 1'b0, BASE);

        foreach (vecs[i]) begin
            run_cycle(vecs[i].v, vecs[i].a, vecs[i].sz, 1'b0);
            check($sformatf("vec%0d_ready", i), 64'(act_ready), 64'(vecs[i].rdy));
            check($sformatf("vec%0d_mem_en", i), 64'(act_mem_en), 64'(vecs[i].en));
            check($sformatf("vec%0d_err", i), 64'(act_err), 64'(vecs[i].err));
            if (vecs[i].rdy) check($sformatf("vec%0d_rdata", i), 64'(act_rdata), 64'(vecs[i].rdata));
        end

        // Redirect during WAIT: 0100 is filled but never answered, 0200 follows.
        run_cycle(1, 64'h8000_0100, 3'b010, 0);
        run_cycle(1, 64'h8000_0100, 3'b010, 0);
        run_cycle(1, 64'h8000_0200, 3'b010, 0);
        run_cycle(1, 64'h8000_0200, 3'b010, 0);
        check("tag_after_0100_fill", 64'(dut.u_linebuf.tag), 64'h8000_0100 >> 3);
        seen = 1'b0;
        at   = -1;
        for (int k = 0; k < 12; k++) begin
            run_cycle(1, 64'h8000_0200, 3'b010, 0);
            if (act_ready) begin
                seen = 1'b1;
                at   = k;
                break;
            end
        end
        check("0200_served", 64'(seen), 64'd1);
        check("0200_cycles", 64'(at), 64'(L + 3));
        check("0200_rdata", 64'(act_rdata), 64'(mem_word(64'h40) & 64'hFFFF_FFFF));

        // Invalidate on WAIT's final cycle: ready still given, refetch misses.
        run_cycle(1, 64'h8000_0300, 3'b010, 0);
        run_cycle(1, 64'h8000_0300, 3'b010, 0);
        run_cycle(1, 64'h8000_0300, 3'b010, 0);
        run_cycle(1, 64'h8000_0300, 3'b010, 1);
        run_cycle(1, 64'h8000_0300, 3'b010, 0);
        check("inv_fill_ready", 64'(act_ready), 64'd1);
        run_cycle(1, 64'h8000_0300, 3'b010, 0);
        run_cycle(1, 64'h8000_0300, 3'b010, 0);
        check("inv_refetch_mem_en", 64'(act_mem_en), 64'd1);
        for (int k = 0; k < 6; k++) run_cycle(0, BASE, 3'b010, 0);

        // Reset during WAIT: no ready, same address misses afterwards.
        run_cycle(1, 64'h8000_0400, 3'b010, 0);
        run_cycle(1, 64'h8000_0400, 3'b010, 0);
        do_reset(2, 1'b1, 64'h8000_0400);
        run_cycle(1, 64'h8000_0400, 3'b010, 0);
        check("post_rst_no_ready", 64'(act_ready), 64'd0);
        run_cycle(1, 64'h8000_0400, 3'b010, 0);
        check("post_rst_mem_en", 64'(act_mem_en), 64'd1);
        for (int k = 0; k < 6; k++) run_cycle(0, BASE, 3'b010, 0);

        // Random initiator: mostly held requests over a few words, occasional
        // redirects, drops, illegal requests and invalidates.
        rv = 1'b1;
        ra = BASE;
        rs = 3'b010;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                rv = ($urandom_range(0, 7) != 0);
                case ($urandom_range(0, 15))
                    0:       ra = BASE - 64'd4;
                    1:       ra = BASE + 64'd2 + 64'(4 * $urandom_range(0, 15));
                    2:       ra = BASE + (64'd8 << AW) + 64'(4 * $urandom_range(0, 3));
                    default: ra = BASE + 64'(4 * $urandom_range(0, 15))
                                  + 64'(32'h1000 * $urandom_range(0, 1));
                endcase
                rs = ($urandom_range(0, 15) == 0) ? 3'b011 : 3'b010;
            end
            run_cycle(rv, ra, rs, $urandom_range(0, 15) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
